// File: rtl/sram_emu_if.sv
// sram_emu_if: async SRAM control/address pin bundle (active-low CS/OE/WE).
// The bidirectional data bus is kept outside the interface as a plain inout
// so tristate resolution stays at the module-port level.
//   master : initiator side, drives addr/cs/oe/we
//   slave  : responder side (sram_emu), samples addr/cs/oe/we
interface sram_emu_if #(
    parameter int ADDR_W = 18
) ();
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;

    modport master (output sram_addr, output sram_cs, output sram_oe, output sram_we);
    modport slave  (input  sram_addr, input  sram_cs, input  sram_oe, input  sram_we);
endinterface

// File: rtl/sram_emu.sv
// sram_emu: block-RAM-backed stand-in for an external async SRAM chip.
// Pins are sampled synchronously on clk; writes commit on the sampled WE
// rising edge while selected, reads come from a 1-cycle sync RAM port.
// Ports:
//   clk, rst_n   clock (rising edge) and async active-low reset
//   bus          sram_emu_if.slave: sram_addr, sram_cs, sram_oe, sram_we
//   sram_data    bidir data, driven only while rd_active, else Z
//   wr_strobe    1-cycle pulse after a write commits
//   rd_active    high while this block drives sram_data
//   wr_count     committed-write counter (0 unless SRAM_EMU_STATS_EN)
//   contention   sticky WE&OE-both-low flag (0 unless SRAM_EMU_STATS_EN)
// Optional feature macro: SRAM_EMU_STATS_EN enables wr_count/contention.
// Memory is not reset; power-up contents are all zero. Addresses at or above
// 2**MEM_ADDR_W alias modulo the depth (MEM_ADDR_W must be below ADDR_W).
module sram_emu #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int MEM_ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_emu_if.slave         bus,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              wr_strobe,
    output logic              rd_active,
    output logic [31:0]       wr_count,
    output logic              contention
);
    localparam int DEPTH = 2 ** MEM_ADDR_W;

    logic [DATA_W-1:0]     mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0]     rd_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  we_q;
    logic                  cs_q;
    logic                  wr_strobe_q;
    logic                  rd_active_q;
    logic                  commit;
    logic                  unused_addr_hi;

    // Upper address bits are deliberately dropped to give modulo aliasing.
    assign unused_addr_hi = ^bus.sram_addr[ADDR_W-1:MEM_ADDR_W];

    // WE rising edge while selected: we_q holds the previous sample.
    assign commit = !we_q && bus.sram_we && !cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b1;
            cs_q        <= 1'b1;
            wr_strobe_q <= 1'b0;
            rd_active_q <= 1'b0;
        end else begin
            addr_q      <= bus.sram_addr[MEM_ADDR_W-1:0];
            data_q      <= sram_data;
            we_q        <= bus.sram_we;
            cs_q        <= bus.sram_cs;
            wr_strobe_q <= commit;
            // WE low wins over OE: never drive while a write is in progress.
            rd_active_q <= !bus.sram_cs && !bus.sram_oe && bus.sram_we;
        end
    end

    // Read and write share one block so a same-address read in the commit
    // cycle returns the old word (read-first).
    always_ff @(posedge clk) begin
        rd_q <= mem[bus.sram_addr[MEM_ADDR_W-1:0]];
        if (commit) begin
            mem[addr_q] <= data_q;
        end
    end

    assign sram_data = rd_active_q ? rd_q : 'z;
    assign wr_strobe = wr_strobe_q;
    assign rd_active = rd_active_q;

`ifdef SRAM_EMU_STATS_EN
    logic [31:0] wr_count_q;
    logic        contention_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q   <= '0;
            contention_q <= 1'b0;
        end else begin
            if (commit) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (!bus.sram_we && !bus.sram_oe && !bus.sram_cs) begin
                contention_q <= 1'b1;
            end
        end
    end

    assign wr_count   = wr_count_q;
    assign contention = contention_q;
`else
    assign wr_count   = '0;
    assign contention = 1'b0;
`endif
endmodule

// File: tb/tb_sram_emu.sv
// tb_sram_emu: randomized self-checking bench for sram_emu against a plain
// word-array model of the SRAM with modulo-depth addressing.
module tb_sram_emu;
    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 16;
    localparam int MEM_ADDR_W = 12;
    localparam int DEPTH      = 2 ** MEM_ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tb_drv = 1'b0;
    logic [DATA_W-1:0] tb_wdata = '0;
    wire  [DATA_W-1:0] sram_data;
    logic              wr_strobe;
    logic              rd_active;
    logic [31:0]       wr_count;
    logic              contention;

    sram_emu_if #(.ADDR_W(ADDR_W)) bus ();

    sram_emu #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_ADDR_W(MEM_ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .sram_data (sram_data),
        .wr_strobe (wr_strobe),
        .rd_active (rd_active),
        .wr_count  (wr_count),
        .contention(contention)
    );

    assign sram_data = tb_drv ? tb_wdata : 'z;

    always #5 clk = ~clk;

    // Reference model
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int unsigned       exp_cnt  = 0;
    bit                exp_cont = 1'b0;
    int                checks   = 0;
    int                errors   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef SRAM_EMU_STATS_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic exp_contention();
`ifdef SRAM_EMU_STATS_EN
        return exp_cont;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned idx(input logic [ADDR_W-1:0] a);
        return int'(a) % DEPTH;
    endfunction

    task automatic pins_idle();
        bus.sram_cs = 1'b1;
        bus.sram_oe = 1'b1;
        bus.sram_we = 1'b1;
        tb_drv      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge. WE low for one clock, then high, then idle.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit sel, input bit oe_low);
        logic [DATA_W-1:0] old;
        bus.sram_addr = a;
        tb_wdata      = d;
        tb_drv        = 1'b1;
        bus.sram_cs   = !sel;
        bus.sram_oe   = !oe_low;
        bus.sram_we   = 1'b0;
        step();
        chk("wr_no_drive", rd_active, 1'b0);
        bus.sram_we = 1'b1;
        tb_drv      = 1'b0;
        old         = ref_mem[idx(a)];
        if (sel && oe_low) exp_cont = 1'b1;
        step();
        if (sel) begin
            ref_mem[idx(a)] = d;
            exp_cnt++;
        end
        chk("wr_strobe", wr_strobe, sel);
        if (sel && oe_low) begin
            chk("rdw_active", rd_active, 1'b1);
            chk("rdw_old", sram_data, old);
        end
        pins_idle();
        step();
        chk("wr_strobe_off", wr_strobe, 1'b0);
        chk("wr_count", wr_count, exp_count());
        chk("contention", contention, exp_contention());
    endtask

    // Called at a negedge; data expected one clock after address/OE applied.
    task automatic do_read(input logic [ADDR_W-1:0] a);
        bus.sram_addr = a;
        bus.sram_cs   = 1'b0;
        bus.sram_oe   = 1'b0;
        bus.sram_we   = 1'b1;
        tb_drv        = 1'b0;
        #1;
        chk("rd_pre_z", rd_active, 1'b0);
        @(negedge clk);
        chk("rd_active", rd_active, 1'b1);
        chk("rd_data", sram_data, ref_mem[idx(a)]);
        pins_idle();
        step();
        chk("rd_off", rd_active, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus.sram_addr = '0;
        pins_idle();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_active", rd_active, 1'b0);
        chk("rst_count", wr_count, 32'd0);
        chk("rst_cont", contention, 1'b0);
        rst_n = 1'b1;
        step();

        // Power-up contents and a basic write/read
        do_read(18'd100);
        do_write(18'd5, 16'h1234, 1'b1, 1'b0);
        do_read(18'd5);

        // Aliasing: upper address bits ignored
        do_write(18'h01010, 16'hAAAA, 1'b1, 1'b0);
        do_read(18'h00010);
        do_read(18'h3F010);

        // CS high: no commit, no drive even with OE low
        do_write(18'd7, 16'hBEEF, 1'b0, 1'b0);
        do_write(18'd7, 16'hBEEF, 1'b0, 1'b1);
        do_read(18'd7);

        // OE and WE both low: no drive, commit on WE rise, read-first
        do_write(18'd5, 16'h5678, 1'b1, 1'b1);
        do_read(18'd5);

        // Back-to-back sweep over 256 addresses
        for (int i = 0; i < 256; i++) begin
            a = ADDR_W'(i + 300);
            d = DATA_W'($urandom);
            do_write(a, d, 1'b1, 1'b0);
        end
        for (int i = 0; i < 256; i++) do_read(ADDR_W'(i + 300));

        // Random mix
        for (int i = 0; i < 200; i++) begin
            a = ADDR_W'($urandom_range(0, 2 ** ADDR_W - 1));
            if (i % 3 == 0) a = ADDR_W'($urandom_range(0, 15));
            d = DATA_W'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
            else
                do_read(a);
        end

        // Reset during a write pulse: nothing commits, stats cleared
        bus.sram_addr = 18'd9;
        tb_wdata      = 16'h5555;
        tb_drv        = 1'b1;
        bus.sram_cs   = 1'b0;
        bus.sram_oe   = 1'b1;
        bus.sram_we   = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        exp_cnt  = 0;
        exp_cont = 1'b0;
        chk("midrst_count", wr_count, 32'd0);
        chk("midrst_active", rd_active, 1'b0);
        chk("midrst_cont", contention, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pins_idle();
        step();
        chk("midrst_strobe0", wr_strobe, 1'b0);
        step();
        chk("midrst_strobe1", wr_strobe, 1'b0);
        do_read(18'd9);
        do_write(18'd11, 16'hC0DE, 1'b1, 1'b0);
        do_read(18'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
